spi_cfg_arbiter: RTL and testbench

Host-side SPI write sequencer that configures the SPI register-file peripheral: two requesters submit (address, data) register writes, a round-robin arbiter grants one at a time, and a frame engine serialises it as a 16-bit SPI mode-0 write frame on ncs/sclk/copi. It sits between on-chip or testbench configuration masters and the peripheral's SPI pins. It holds the peripheral's enable and duty-cycle registers in step with requester intent without software bit-banging.

---
 rtl/spi_cfg_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_cfg_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_arbiter.sv
// Two-requester round-robin register-write sequencer emitting 16-bit SPI mode-0 write frames.
// Optional address check (addr > 7'h04 rejected with err) enabled by defining SPI_ARB_ADDR_CHECK_EN.
module spi_cfg_arbiter #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NCS_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       done,
  output logic       grant_id,
`ifdef SPI_ARB_ADDR_CHECK_EN
  output logic       err,
`endif
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 5;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(NCS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 last_q, last_d;

  logic                 ready0_d, ready1_d, busy_d, done_d, gid_d;
  logic                 ncs_d, sclk_d, copi_d;
`ifdef SPI_ARB_ADDR_CHECK_EN
  logic                 err_d;
`endif

  logic                 sel;
  logic                 grant_ok;
  logic                 addr_bad;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  // Round-robin pick: a tie goes to the requester not granted last.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last_q;
    end
    sel_addr = sel ? req1_addr : req0_addr;
    sel_data = sel ? req1_data : req0_data;
    // Blocks a second grant while the previous ready pulse is still visible.
    grant_ok = (req0_valid || req1_valid) && !(req0_ready || req1_ready);
  end

`ifdef SPI_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = 7'h04;
  assign addr_bad = (sel_addr > ADDR_MAX);
`else
  assign addr_bad = 1'b0;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    last_d   = last_q;
    ready0_d = 1'b0;
    ready1_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy;
    gid_d    = grant_id;
    ncs_d    = ncs;
    sclk_d   = sclk;
    copi_d   = copi;
`ifdef SPI_ARB_ADDR_CHECK_EN
    err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        busy_d = 1'b0;
        if (grant_ok) begin
          last_d   = sel;
          gid_d    = sel;
          ready0_d = ~sel;
          ready1_d = sel;
`ifdef SPI_ARB_ADDR_CHECK_EN
          err_d    = addr_bad;
`endif
          if (!addr_bad) begin
            state_d = S_SETUP;
            div_d   = '0;
            bit_d   = '0;
            shift_d = {1'b1, sel_addr, sel_data};
            busy_d  = 1'b1;
            ncs_d   = 1'b0;
            copi_d  = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      // sclk itself tells which half of the bit period is running.
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk) begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              state_d = S_HOLD;
              bit_d   = '0;
              copi_d  = 1'b0;
            end else begin
              copi_d = shift_q[FRAME_W-2];
            end
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_HOLD: begin
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (div_q == DIV_LAST) begin
          state_d = S_GAP;
          div_d   = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_GAP: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (div_q == GAP_LAST) begin
          state_d = S_IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b1;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      grant_id   <= 1'b0;
      ncs        <= 1'b1;
      sclk       <= 1'b0;
      copi       <= 1'b0;
`ifdef SPI_ARB_ADDR_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      req0_ready <= ready0_d;
      req1_ready <= ready1_d;
      busy       <= busy_d;
      done       <= done_d;
      grant_id   <= gid_d;
      ncs        <= ncs_d;
      sclk       <= sclk_d;
      copi       <= copi_d;
`ifdef SPI_ARB_ADDR_CHECK_EN
      err        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Bench for spi_cfg_arbiter: frame-timeline model checked every cycle on two instances
// (CLK_DIV/NCS_GAP = 4/4 and 1/1), plus directed literal expectations.
module tb_spi_cfg_arbiter;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned GAP_A = 4;
  localparam int unsigned DIV_B = 1;
  localparam int unsigned GAP_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, r0v, r1v;
  logic [6:0] r0a [2];
  logic [6:0] r1a [2];
  logic [7:0] r0d [2];
  logic [7:0] r1d [2];
  wire  [1:0] rdy0, rdy1, busy, done, gid, ncs, sclk, copi;
`ifdef SPI_ARB_ADDR_CHECK_EN
  wire  [1:0] err;
`endif

  spi_cfg_arbiter #(.CLK_DIV(DIV_A), .NCS_GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst_v[0]),
    .req0_valid(r0v[0]), .req0_addr(r0a[0]), .req0_data(r0d[0]), .req0_ready(rdy0[0]),
    .req1_valid(r1v[0]), .req1_addr(r1a[0]), .req1_data(r1d[0]), .req1_ready(rdy1[0]),
    .busy(busy[0]), .done(done[0]), .grant_id(gid[0]),
`ifdef SPI_ARB_ADDR_CHECK_EN
    .err(err[0]),
`endif
    .ncs(ncs[0]), .sclk(sclk[0]), .copi(copi[0])
  );

  spi_cfg_arbiter #(.CLK_DIV(DIV_B), .NCS_GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst_v[1]),
    .req0_valid(r0v[1]), .req0_addr(r0a[1]), .req0_data(r0d[1]), .req0_ready(rdy0[1]),
    .req1_valid(r1v[1]), .req1_addr(r1a[1]), .req1_data(r1d[1]), .req1_ready(rdy1[1]),
    .busy(busy[1]), .done(done[1]), .grant_id(gid[1]),
`ifdef SPI_ARB_ADDR_CHECK_EN
    .err(err[1]),
`endif
    .ncs(ncs[1]), .sclk(sclk[1]), .copi(copi[1])
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Inputs as the DUT saw them at the last rising edge.
  logic [1:0] s_rst, s_r0v, s_r1v;
  logic [6:0] s_r0a [2];
  logic [6:0] s_r1a [2];
  logic [7:0] s_r0d [2];
  logic [7:0] s_r1d [2];
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    s_rst <= rst_v;
    s_r0v <= r0v;
    s_r1v <= r1v;
    s_r0a <= r0a;
    s_r1a <= r1a;
    s_r0d <= r0d;
    s_r1d <= r1d;
  end

  function automatic int dv(input int i);
    return (i == 0) ? int'(DIV_A) : int'(DIV_B);
  endfunction
  function automatic int gp(input int i);
    return (i == 0) ? int'(GAP_A) : int'(GAP_B);
  endfunction

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cyc=%0d got=%b want=%b", name, i, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Model: a frame is a timeline k = 0 .. 33*D+G-1 counted from the ready cycle.
  bit          m_act  [2];
  int          m_k    [2];
  logic [15:0] m_frame[2];
  bit          m_last [2];
  bit          m_gid  [2];
  bit          m_r0   [2];
  bit          m_r1   [2];
  bit          m_prev [2];
`ifdef SPI_ARB_ADDR_CHECK_EN
  bit          m_err  [2];
`endif

  // Measurements used by the directed checks.
  bit          p_ncs    [2] = '{1'b1, 1'b1};
  bit          p_sclk   [2] = '{1'b0, 1'b0};
  int          low_run  [2] = '{0, 0};
  int          last_low [2] = '{0, 0};
  int          low_total[2] = '{0, 0};
  int          sedges   [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          r1_cnt   [2] = '{0, 0};
  logic [15:0] cap      [2];
  bit          glog[$];
  int          gcyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < 2; i++) begin
          int  d, k, j, b;
          bit  w, hi;
          logic [6:0] a;
          logic [7:0] dd;
          logic e_ncs, e_sclk, e_copi;
          d = dv(i);
          m_r0[i] = 1'b0;
          m_r1[i] = 1'b0;
`ifdef SPI_ARB_ADDR_CHECK_EN
          m_err[i] = 1'b0;
`endif
          if (s_rst[i]) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_last[i] = 1'b1; m_gid[i] = 1'b0;
          end else if (m_act[i]) begin
            m_k[i]++;
            if (m_k[i] == 33 * d + gp(i)) m_act[i] = 1'b0;
          end else if ((s_r0v[i] || s_r1v[i]) && !m_prev[i]) begin
            w  = (s_r0v[i] && s_r1v[i]) ? !m_last[i] : s_r1v[i];
            a  = w ? s_r1a[i] : s_r0a[i];
            dd = w ? s_r1d[i] : s_r0d[i];
            m_last[i] = w; m_gid[i] = w;
            m_r0[i] = !w;  m_r1[i] = w;
`ifdef SPI_ARB_ADDR_CHECK_EN
            if (a > 7'h04) m_err[i] = 1'b1;
            else
`endif
            begin
              m_act[i] = 1'b1; m_k[i] = 0; m_frame[i] = {1'b1, a, dd};
            end
          end
          m_prev[i] = m_r0[i] || m_r1[i];

          k = m_k[i];
          e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0;
          if (m_act[i] && k < 33 * d) begin
            e_ncs = 1'b0;
            if (k < d) begin
              e_copi = m_frame[i][15];
            end else begin
              j  = k - d;
              b  = j / (2 * d);
              hi = (j % (2 * d)) < d;
              e_sclk = hi;
              e_copi = hi ? m_frame[i][15-b] : ((b < 15) ? m_frame[i][14-b] : 1'b0);
            end
          end

          chk("ncs", i, ncs[i], e_ncs);
          chk("sclk", i, sclk[i], e_sclk);
          chk("copi", i, copi[i], e_copi);
          chk("busy", i, busy[i], m_act[i]);
          chk("done", i, done[i], m_act[i] && (k == 33 * d));
          chk("ready0", i, rdy0[i], m_r0[i]);
          chk("ready1", i, rdy1[i], m_r1[i]);
          chk("grant_id", i, gid[i], m_gid[i]);
`ifdef SPI_ARB_ADDR_CHECK_EN
          chk("err", i, err[i], m_err[i]);
`endif

          if (ncs[i] === 1'b0) begin
            if (p_ncs[i]) begin low_run[i] = 0; cap[i] = '0; sedges[i] = 0; end
            low_run[i]++;
            low_total[i]++;
            if (sclk[i] !== p_sclk[i]) sedges[i]++;
          end else if (!p_ncs[i]) begin
            last_low[i] = low_run[i];
          end
          if (sclk[i] === 1'b1 && !p_sclk[i]) cap[i] = {cap[i][14:0], copi[i]};
          if (done[i] === 1'b1) done_cnt[i]++;
          if (rdy1[i] === 1'b1) r1_cnt[i]++;
          if (i == 0 && (rdy0[0] === 1'b1 || rdy1[0] === 1'b1)) begin
            glog.push_back(rdy1[0]);
            gcyc.push_back(cyc);
          end
          p_ncs[i]  = (ncs[i] === 1'b1);
          p_sclk[i] = (sclk[i] === 1'b1);
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int i, input bit who);
    int n = 0;
    do begin
      tick;
      n++;
    end while (((who ? rdy1[i] : rdy0[i]) !== 1'b1) && n < 1000);
    chk_int("ready_wait", int'(n < 1000), 1);
  endtask

  task automatic wr(input int i, input bit who, input logic [6:0] a, input logic [7:0] d);
    if (who) begin r1a[i] = a; r1d[i] = d; r1v[i] = 1'b1; end
    else     begin r0a[i] = a; r0d[i] = d; r0v[i] = 1'b1; end
    wait_rdy(i, who);
    if (who) r1v[i] = 1'b0;
    else     r0v[i] = 1'b0;
  endtask

  task automatic wait_quiet(input int i);
    int n = 0;
    while (busy[i] !== 1'b0 && n < 3000) begin
      tick;
      n++;
    end
    chk_int("quiet_wait", int'(n < 3000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_done, c_r1, c_low;
    rst_v = 2'b11;
    r0v = '0;
    r1v = '0;
    for (int i = 0; i < 2; i++) begin
      r0a[i] = '0; r1a[i] = '0; r0d[i] = '0; r1d[i] = '0;
    end
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ncs", i, ncs[i], 1'b1);
      chk("rst_sclk", i, sclk[i], 1'b0);
      chk("rst_copi", i, copi[i], 1'b0);
      chk("rst_busy", i, busy[i], 1'b0);
      chk("rst_ready0", i, rdy0[i], 1'b0);
      chk("rst_grant_id", i, gid[i], 1'b0);
    end
    rst_v = 2'b00;
    tick;

    // Single write from requester 0.
    wr(0, 1'b0, 7'h04, 8'hA5);
    wait_quiet(0);
    chk_int("single_bits", int'(cap[0]), 16'h84A5);
    chk_int("single_ncs_low", last_low[0], 132);
    chk_int("single_done", done_cnt[0], 1);
    chk_int("single_gid", int'(gid[0]), 0);

    // Edge parameters on the second instance.
    wr(1, 1'b0, 7'h03, 8'hFF);
    wait_quiet(1);
    chk_int("edge_bits", int'(cap[1]), 16'h83FF);
    chk_int("edge_ncs_low", last_low[1], 33);
    chk_int("edge_sclk_toggles", sedges[1], 32);
    chk_int("edge_done", done_cnt[1], 1);

    // Both requesters valid out of reset.
    rst_v[0] = 1'b1;
    r0a[0] = 7'h00; r0d[0] = 8'h11; r0v[0] = 1'b1;
    r1a[0] = 7'h01; r1d[0] = 8'h33; r1v[0] = 1'b1;
    repeat (2) tick;
    glog.delete();
    gcyc.delete();
    rst_v[0] = 1'b0;
    fork
      begin
        for (int n = 0; n < 2; n++) begin wait_rdy(0, 1'b0); r0d[0] = 8'h22; end
        r0v[0] = 1'b0;
      end
      begin
        for (int n = 0; n < 2; n++) begin wait_rdy(0, 1'b1); r1d[0] = 8'h44; end
        r1v[0] = 1'b0;
      end
    join
    wait_quiet(0);
    chk_int("tie_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk_int("tie_g0", int'(glog[0]), 0);
      chk_int("tie_g1", int'(glog[1]), 1);
      chk_int("tie_g2", int'(glog[2]), 0);
      chk_int("tie_g3", int'(glog[3]), 1);
      chk_int("tie_period01", gcyc[1] - gcyc[0], 137);
      chk_int("tie_period23", gcyc[3] - gcyc[2], 137);
    end

    // Requester 1 withdraws before being served.
    c_done = done_cnt[0];
    c_r1   = r1_cnt[0];
    wr(0, 1'b0, 7'h02, 8'h5A);
    repeat (10) tick;
    r1a[0] = 7'h01; r1d[0] = 8'h77; r1v[0] = 1'b1;
    repeat (2) tick;
    r1v[0] = 1'b0;
    wait_quiet(0);
    repeat (20) tick;
    chk_int("withdraw_ready1", r1_cnt[0] - c_r1, 0);
    chk_int("withdraw_frames", done_cnt[0] - c_done, 1);
    chk_int("withdraw_busy", int'(busy[0]), 0);

    // Reset in the middle of a frame.
    wr(0, 1'b0, 7'h01, 8'h3C);
    repeat (20) tick;
    c_done = done_cnt[0];
    rst_v[0] = 1'b1;
    tick;
    chk_int("midrst_ncs", int'(ncs[0]), 1);
    chk_int("midrst_sclk", int'(sclk[0]), 0);
    chk_int("midrst_busy", int'(busy[0]), 0);
    repeat (2) tick;
    rst_v[0] = 1'b0;
    repeat (150) tick;
    chk_int("midrst_no_done", done_cnt[0] - c_done, 0);

    // Out-of-range address.
    c_done = done_cnt[0];
    c_low  = low_total[0];
    wr(0, 1'b0, 7'h05, 8'h99);
`ifdef SPI_ARB_ADDR_CHECK_EN
    chk_int("addr_err_with_ready", int'(err[0]), 1);
    repeat (150) tick;
    chk_int("addr_ncs_held", low_total[0] - c_low, 0);
    chk_int("addr_no_done", done_cnt[0] - c_done, 0);
`else
    wait_quiet(0);
    chk_int("addr_ncs_low", last_low[0], 132);
    chk_int("addr_done", done_cnt[0] - c_done, 1);
`endif
    repeat (5) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
